// File: rtl/pa_lsu_vb_entry_mb_if.sv
// Victim-buffer entry port bundle: fill/lookup/store from the LSU, writeback handshake with the BIU.
// The entry connects through 'slave'; the driving environment uses 'master'.
interface pa_lsu_vb_entry_mb_if #(
  parameter int unsigned BEATS  = 4,
  parameter int unsigned BEAT_W = 64,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned TAG_W  = 27,
  parameter int unsigned FWD_W  = 32
) ();
  localparam int unsigned CNT_W = $clog2(BEATS);
  localparam int unsigned BE_W  = FWD_W / 8;

  logic              rtu_yy_xx_async_flush;
  logic              vb_create_en_x;
  logic [TAG_W-1:0]  vb_create_addr;
  logic              vb_create_line_dirty;
  logic              vb_create_data_vld;
  logic [CNT_W-1:0]  vb_create_data_cnt;
  logic [BEAT_W-1:0] vb_create_data;
  logic              vb_clr_en_x;
  logic [ADDR_W-1:0] dc_xx_addr;
  logic              dc_vb_st_vld;
  logic              dc_vb_st_merge;
  logic [FWD_W-1:0]  dc_vb_st_data;
  logic [BE_W-1:0]   dc_vb_st_be;
  logic              vb_wb_grant_x;
  logic              vb_wb_beat_rdy;
  logic              vb_wb_cmplt_x;
  logic              vb_entry_vld_x;
  logic              vb_entry_biu_req_x;
  logic [TAG_W-1:0]  vb_entryx_addr;
  logic              vb_wb_beat_vld;
  logic [CNT_W-1:0]  vb_wb_beat_idx;
  logic              vb_wb_beat_last;
  logic [BEAT_W-1:0] vb_wb_data;
  logic              vb_fwd_vld_x;
  logic [FWD_W-1:0]  vb_entryx_fwd_data;
  logic              vb_hit_dirty_x;
  logic              vb_pop_en_x;
  logic [2:0]        vb_entryx_dbginfo;

  modport slave (
    input  rtu_yy_xx_async_flush, vb_create_en_x, vb_create_addr, vb_create_line_dirty,
           vb_create_data_vld, vb_create_data_cnt, vb_create_data, vb_clr_en_x, dc_xx_addr,
           dc_vb_st_vld, dc_vb_st_merge, dc_vb_st_data, dc_vb_st_be, vb_wb_grant_x,
           vb_wb_beat_rdy, vb_wb_cmplt_x,
    output vb_entry_vld_x, vb_entry_biu_req_x, vb_entryx_addr, vb_wb_beat_vld, vb_wb_beat_idx,
           vb_wb_beat_last, vb_wb_data, vb_fwd_vld_x, vb_entryx_fwd_data, vb_hit_dirty_x,
           vb_pop_en_x, vb_entryx_dbginfo
  );

  modport master (
    output rtu_yy_xx_async_flush, vb_create_en_x, vb_create_addr, vb_create_line_dirty,
           vb_create_data_vld, vb_create_data_cnt, vb_create_data, vb_clr_en_x, dc_xx_addr,
           dc_vb_st_vld, dc_vb_st_merge, dc_vb_st_data, dc_vb_st_be, vb_wb_grant_x,
           vb_wb_beat_rdy, vb_wb_cmplt_x,
    input  vb_entry_vld_x, vb_entry_biu_req_x, vb_entryx_addr, vb_wb_beat_vld, vb_wb_beat_idx,
           vb_wb_beat_last, vb_wb_data, vb_fwd_vld_x, vb_entryx_fwd_data, vb_hit_dirty_x,
           vb_pop_en_x, vb_entryx_dbginfo
  );
endinterface

// File: rtl/pa_lsu_vb_entry_mb.sv
// Victim-buffer entry: holds one evicted line, forwards loads, merges byte-masked stores
// while RDY, and writes the line back beat by beat under a per-beat BIU handshake.
module pa_lsu_vb_entry_mb #(
  parameter int unsigned BEATS  = 4,
  parameter int unsigned BEAT_W = 64,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned TAG_W  = 27,
  parameter int unsigned FWD_W  = 32
) (
  input logic                  vb_clk,
  input logic                  cpurst_b,
  pa_lsu_vb_entry_mb_if.slave  vb
);
  localparam int unsigned CNT_W      = $clog2(BEATS);
  localparam int unsigned BE_W       = FWD_W / 8;
  localparam int unsigned BYTE_SEL_W = $clog2(BE_W);
  localparam int unsigned WSEL_W     = ADDR_W - TAG_W - BYTE_SEL_W;
  localparam int unsigned LINE_W     = BEATS * BEAT_W;
  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StRfc  = 3'd1,
    StRdy  = 3'd2,
    StWfc  = 3'd3,
    StWb   = 3'd4,
    StWd   = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic               dirty_q, dirty_d;
  logic [TAG_W-1:0]   tag_q;
  logic [LINE_W-1:0]  line_q;
  logic               flush, resident, hit, st_hit, merge, evict, pop;
  logic               tag_we, fill_we, merge_we;
  logic [WSEL_W-1:0]  wsel;

  assign flush    = vb.rtu_yy_xx_async_flush;
  assign resident = state_q inside {StRdy, StWb, StWd, StWfc};
  assign hit      = resident & (vb.dc_xx_addr[ADDR_W-1 -: TAG_W] == tag_q);
  assign wsel     = vb.dc_xx_addr[BYTE_SEL_W +: WSEL_W];
  // Stores only modify the line in RDY; in WB/WD/WFC upstream stalls on hit_dirty.
  assign st_hit   = vb.dc_vb_st_vld & hit & (state_q == StRdy);
  assign merge    = st_hit & vb.dc_vb_st_merge;
  assign evict    = st_hit & ~vb.dc_vb_st_merge;
  assign tag_we   = (state_q == StIdle) & vb.vb_create_en_x & ~flush;
  assign fill_we  = (state_q == StRfc) & vb.vb_create_data_vld & ~flush;
  assign merge_we = merge & ~flush;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dirty_d = dirty_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: if (vb.vb_create_en_x) begin
        state_d = StRfc;
        dirty_d = vb.vb_create_line_dirty;
      end
      StRfc: if (vb.vb_create_data_vld && vb.vb_create_data_cnt == LastIdx) state_d = StRdy;
      StRdy: begin
        if (merge) dirty_d = 1'b1;
        if (vb.vb_clr_en_x || evict) begin
          if (dirty_q || merge) begin
            state_d = StWb;
          end else begin
            state_d = StIdle;
            pop     = 1'b1;
          end
        end
      end
      StWb: if (vb.vb_wb_grant_x) begin
        state_d = StWd;
        idx_d   = '0;
      end
      StWd: if (vb.vb_wb_beat_rdy) begin
        if (idx_q == LastIdx) begin
          state_d = StWfc;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StWfc: if (vb.vb_wb_cmplt_x) begin
        state_d = StIdle;
        pop     = 1'b1;
      end
      default: state_d = StIdle;
    endcase
    if (flush) begin
      state_d = StIdle;
      idx_d   = '0;
      dirty_d = 1'b0;
      pop     = 1'b0;
    end
  end

  always_ff @(posedge vb_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q <= StIdle;
      idx_q   <= '0;
      dirty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and line storage carry no reset and survive a flush.
  always_ff @(posedge vb_clk) begin
    if (tag_we) tag_q <= vb.vb_create_addr;
    if (fill_we) line_q[vb.vb_create_data_cnt*BEAT_W +: BEAT_W] <= vb.vb_create_data;
    if (merge_we) begin
      for (int b = 0; b < int'(BE_W); b++) begin
        if (vb.dc_vb_st_be[b]) line_q[wsel*FWD_W + b*8 +: 8] <= vb.dc_vb_st_data[b*8 +: 8];
      end
    end
  end

  assign vb.vb_entry_vld_x      = (state_q != StIdle);
  assign vb.vb_entry_biu_req_x  = (state_q == StWb);
  assign vb.vb_entryx_addr      = tag_q;
  assign vb.vb_wb_beat_vld      = (state_q == StWd);
  assign vb.vb_wb_beat_idx      = idx_q;
  assign vb.vb_wb_beat_last     = (state_q == StWd) & (idx_q == LastIdx);
  assign vb.vb_wb_data          = line_q[idx_q*BEAT_W +: BEAT_W];
  assign vb.vb_fwd_vld_x        = hit;
  assign vb.vb_entryx_fwd_data  = line_q[wsel*FWD_W +: FWD_W];
  assign vb.vb_hit_dirty_x      = hit & dirty_q;
  assign vb.vb_pop_en_x         = pop;
  assign vb.vb_entryx_dbginfo   = state_q;
endmodule

// File: tb/tb_pa_lsu_vb_entry_mb.sv
// Bench for pa_lsu_vb_entry_mb: directed fill/lookup/merge/writeback/flush sequences with a
// scoreboard of expected writeback beats checked whenever the BIU accepts a beat.
module tb_pa_lsu_vb_entry_mb;
  localparam logic [26:0] Tag = 27'h1234567;

  logic vb_clk = 1'b0;
  logic cpurst_b;
  always #5 vb_clk = ~vb_clk;

  pa_lsu_vb_entry_mb_if vb ();

  pa_lsu_vb_entry_mb dut (
    .vb_clk   (vb_clk),
    .cpurst_b (cpurst_b),
    .vb       (vb)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  idx;
    logic        last;
  } wb_beat_t;

  wb_beat_t    sb_q[$];
  logic [63:0] m[4];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge vb_clk);
    #1;
  endtask

  function automatic logic [31:0] laddr(input logic [26:0] t, input logic [4:0] off);
    return {t, off};
  endfunction

  // Every accepted beat must match the next expected beat in order.
  always @(negedge vb_clk) begin
    if (cpurst_b && vb.vb_wb_beat_vld && vb.vb_wb_beat_rdy) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_unexpected_beat", 64'd1, 64'd0);
      end else begin
        wb_beat_t e;
        e = sb_q.pop_front();
        check_eq("wb_data", vb.vb_wb_data, e.data);
        check_eq("wb_idx", 64'(vb.vb_wb_beat_idx), 64'(e.idx));
        check_eq("wb_last", 64'(vb.vb_wb_beat_last), 64'(e.last));
      end
    end
  end

  task automatic create_line(input logic [26:0] t, input logic dirty, input logic [7:0] base);
    vb.vb_create_en_x       = 1'b1;
    vb.vb_create_addr       = t;
    vb.vb_create_line_dirty = dirty;
    step();
    vb.vb_create_en_x = 1'b0;
    check_eq("create_rfc", 64'(vb.vb_entryx_dbginfo), 64'd1);
    for (int b = 0; b < 4; b++) begin
      logic [7:0] byt;
      byt = base + 8'(b) * 8'h11;
      m[b] = {8{byt}};
      vb.vb_create_data_vld = 1'b1;
      vb.vb_create_data_cnt = 2'(b);
      vb.vb_create_data     = m[b];
      step();
      check_eq("fill_state", 64'(vb.vb_entryx_dbginfo), (b == 3) ? 64'd2 : 64'd1);
    end
    vb.vb_create_data_vld = 1'b0;
  endtask

  task automatic push_wb();
    for (int b = 0; b < 4; b++) sb_q.push_back('{data: m[b], idx: 2'(b), last: (b == 3)});
  endtask

  task automatic grant_wb();
    vb.vb_wb_grant_x = 1'b1;
    step();
    vb.vb_wb_grant_x = 1'b0;
    check_eq("wd_enter", 64'(vb.vb_entryx_dbginfo), 64'd5);
    check_eq("wd_idx0", 64'(vb.vb_wb_beat_idx), 64'd0);
    check_eq("wd_beat0", vb.vb_wb_data, m[0]);
  endtask

  task automatic finish_wb();
    check_eq("wfc_state", 64'(vb.vb_entryx_dbginfo), 64'd3);
    check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
    vb.vb_wb_cmplt_x = 1'b1;
    #1;
    check_eq("cmplt_pop", 64'(vb.vb_pop_en_x), 64'd1);
    step();
    vb.vb_wb_cmplt_x = 1'b0;
    check_eq("cmplt_idle", 64'(vb.vb_entryx_dbginfo), 64'd0);
    check_eq("cmplt_pop_off", 64'(vb.vb_pop_en_x), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    vb.rtu_yy_xx_async_flush = 0; vb.vb_create_en_x = 0; vb.vb_create_addr = '0;
    vb.vb_create_line_dirty = 0; vb.vb_create_data_vld = 0; vb.vb_create_data_cnt = '0;
    vb.vb_create_data = '0; vb.vb_clr_en_x = 0; vb.dc_xx_addr = '0; vb.dc_vb_st_vld = 0;
    vb.dc_vb_st_merge = 0; vb.dc_vb_st_data = '0; vb.dc_vb_st_be = '0;
    vb.vb_wb_grant_x = 0; vb.vb_wb_beat_rdy = 0; vb.vb_wb_cmplt_x = 0;
    cpurst_b = 1'b0;
    step();
    step();
    check_eq("rst_vld", 64'(vb.vb_entry_vld_x), 64'd0);
    check_eq("rst_req", 64'(vb.vb_entry_biu_req_x), 64'd0);
    check_eq("rst_beat_vld", 64'(vb.vb_wb_beat_vld), 64'd0);
    check_eq("rst_idx", 64'(vb.vb_wb_beat_idx), 64'd0);
    check_eq("rst_last", 64'(vb.vb_wb_beat_last), 64'd0);
    check_eq("rst_fwd_vld", 64'(vb.vb_fwd_vld_x), 64'd0);
    check_eq("rst_hit_dirty", 64'(vb.vb_hit_dirty_x), 64'd0);
    check_eq("rst_pop", 64'(vb.vb_pop_en_x), 64'd0);
    check_eq("rst_state", 64'(vb.vb_entryx_dbginfo), 64'd0);
    cpurst_b = 1'b1;
    step();

    // Clean line: fill, forward, ignored create, clean release.
    create_line(Tag, 1'b0, 8'h11);
    check_eq("rdy_vld", 64'(vb.vb_entry_vld_x), 64'd1);
    check_eq("rdy_addr", 64'(vb.vb_entryx_addr), 64'(Tag));
    vb.dc_xx_addr = laddr(Tag, 5'h14);
    #1;
    check_eq("fwd_vld", 64'(vb.vb_fwd_vld_x), 64'd1);
    check_eq("fwd_data", 64'(vb.vb_entryx_fwd_data), 64'h33333333);
    check_eq("fwd_clean", 64'(vb.vb_hit_dirty_x), 64'd0);
    vb.dc_xx_addr = laddr(27'h1234566, 5'h14);
    #1;
    check_eq("fwd_miss", 64'(vb.vb_fwd_vld_x), 64'd0);
    vb.vb_create_en_x = 1'b1;
    vb.vb_create_addr = 27'h0000001;
    step();
    vb.vb_create_en_x = 1'b0;
    check_eq("create_ignored_st", 64'(vb.vb_entryx_dbginfo), 64'd2);
    check_eq("create_ignored_tag", 64'(vb.vb_entryx_addr), 64'(Tag));
    vb.dc_xx_addr = laddr(Tag, 5'h00);
    vb.vb_clr_en_x = 1'b1;
    #1;
    check_eq("clr_pop", 64'(vb.vb_pop_en_x), 64'd1);
    check_eq("clr_hit_dirty", 64'(vb.vb_hit_dirty_x), 64'd0);
    step();
    vb.vb_clr_en_x = 1'b0;
    check_eq("clr_idle", 64'(vb.vb_entryx_dbginfo), 64'd0);
    check_eq("clr_vld_off", 64'(vb.vb_entry_vld_x), 64'd0);

    // Merge into a clean line, then writeback with a stalled beat 1.
    create_line(Tag, 1'b0, 8'h11);
    vb.dc_xx_addr     = laddr(Tag, 5'h08);
    vb.dc_vb_st_vld   = 1'b1;
    vb.dc_vb_st_merge = 1'b1;
    vb.dc_vb_st_data  = 32'hAABBCCDD;
    vb.dc_vb_st_be    = 4'b0011;
    #1;
    check_eq("merge_no_bypass", 64'(vb.vb_entryx_fwd_data), 64'h22222222);
    step();
    vb.dc_vb_st_vld = 1'b0;
    m[1][15:0] = 16'hCCDD;
    check_eq("merge_fwd", 64'(vb.vb_entryx_fwd_data), 64'h2222CCDD);
    check_eq("merge_dirty", 64'(vb.vb_hit_dirty_x), 64'd1);
    check_eq("merge_stay_rdy", 64'(vb.vb_entryx_dbginfo), 64'd2);
    vb.vb_clr_en_x = 1'b1;
    #1;
    check_eq("dirty_clr_no_pop", 64'(vb.vb_pop_en_x), 64'd0);
    step();
    vb.vb_clr_en_x = 1'b0;
    check_eq("dirty_clr_wb", 64'(vb.vb_entry_biu_req_x), 64'd1);
    push_wb();
    grant_wb();
    vb.vb_wb_beat_rdy = 1'b1;
    step();
    vb.vb_wb_beat_rdy = 1'b0;
    for (int s = 0; s < 2; s++) begin
      step();
      check_eq("stall_idx", 64'(vb.vb_wb_beat_idx), 64'd1);
      check_eq("stall_data", vb.vb_wb_data, m[1]);
      check_eq("stall_vld", 64'(vb.vb_wb_beat_vld), 64'd1);
    end
    vb.vb_wb_beat_rdy = 1'b1;
    repeat (3) step();
    vb.vb_wb_beat_rdy = 1'b0;
    finish_wb();

    // Dirty line evicted by a non-merge store, flushed mid-writeback.
    create_line(Tag, 1'b1, 8'h30);
    vb.dc_xx_addr     = laddr(Tag, 5'h04);
    vb.dc_vb_st_vld   = 1'b1;
    vb.dc_vb_st_merge = 1'b0;
    #1;
    check_eq("evict_hit_dirty", 64'(vb.vb_hit_dirty_x), 64'd1);
    check_eq("evict_no_pop", 64'(vb.vb_pop_en_x), 64'd0);
    step();
    vb.dc_vb_st_vld = 1'b0;
    check_eq("evict_biu_req", 64'(vb.vb_entry_biu_req_x), 64'd1);
    push_wb();
    grant_wb();
    vb.vb_wb_beat_rdy = 1'b1;
    repeat (2) step();
    vb.vb_wb_beat_rdy = 1'b0;
    vb.rtu_yy_xx_async_flush = 1'b1;
    #1;
    check_eq("flush_at_beat2", 64'(vb.vb_wb_beat_idx), 64'd2);
    check_eq("flush_no_pop", 64'(vb.vb_pop_en_x), 64'd0);
    step();
    vb.rtu_yy_xx_async_flush = 1'b0;
    check_eq("flush_idle", 64'(vb.vb_entryx_dbginfo), 64'd0);
    check_eq("flush_beat_vld", 64'(vb.vb_wb_beat_vld), 64'd0);
    check_eq("flush_pop", 64'(vb.vb_pop_en_x), 64'd0);
    check_eq("flush_sb_left", 64'(sb_q.size()), 64'd2);
    sb_q.delete();
    create_line(Tag, 1'b1, 8'h50);
    vb.vb_clr_en_x = 1'b1;
    step();
    vb.vb_clr_en_x = 1'b0;
    check_eq("recreate_wb", 64'(vb.vb_entryx_dbginfo), 64'd4);
    push_wb();
    grant_wb();
    vb.vb_wb_beat_rdy = 1'b1;
    repeat (4) step();
    vb.vb_wb_beat_rdy = 1'b0;
    finish_wb();

    // Merge and release together on a clean line; later store in WB must not merge.
    create_line(Tag, 1'b0, 8'h11);
    vb.dc_xx_addr     = laddr(Tag, 5'h1C);
    vb.dc_vb_st_vld   = 1'b1;
    vb.dc_vb_st_merge = 1'b1;
    vb.dc_vb_st_data  = 32'h99000000;
    vb.dc_vb_st_be    = 4'b1000;
    vb.vb_clr_en_x    = 1'b1;
    #1;
    check_eq("merge_clr_no_pop", 64'(vb.vb_pop_en_x), 64'd0);
    step();
    vb.dc_vb_st_vld = 1'b0;
    vb.vb_clr_en_x  = 1'b0;
    m[3][63:56] = 8'h99;
    check_eq("merge_clr_wb", 64'(vb.vb_entryx_dbginfo), 64'd4);
    vb.dc_xx_addr    = laddr(Tag, 5'h00);
    vb.dc_vb_st_vld  = 1'b1;
    vb.dc_vb_st_data = 32'hDEADBEEF;
    vb.dc_vb_st_be   = 4'b1111;
    #1;
    check_eq("wb_st_fwd_vld", 64'(vb.vb_fwd_vld_x), 64'd1);
    check_eq("wb_st_hit_dirty", 64'(vb.vb_hit_dirty_x), 64'd1);
    step();
    vb.dc_vb_st_vld = 1'b0;
    check_eq("wb_st_no_merge", 64'(vb.vb_entryx_fwd_data), 64'h11111111);
    check_eq("wb_st_stay", 64'(vb.vb_entryx_dbginfo), 64'd4);
    push_wb();
    grant_wb();
    vb.vb_wb_beat_rdy = 1'b1;
    repeat (4) step();
    vb.vb_wb_beat_rdy = 1'b0;
    finish_wb();

    check_eq("sb_final_empty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/pa_lsu_vb_entry_mb.md
Name: pa_lsu_vb_entry_mb

Overview:
Parametrised victim-buffer entry for the LSU. Holds one evicted cache line of BEATS x BEAT_W bits and forwards load data while the line is resident. Adds two behaviours to the existing single-line entry: byte-masked store merge into a resident line, and a beat-serial writeback with per-beat handshake to the BIU. One instance per VB slot; the VB top arbitrates create, clear and writeback grant across instances.

Parameters:
BEATS, 4, beats per line; power of 2, >=2
BEAT_W, 64, bits per fill/writeback beat
ADDR_W, 32, physical address width
TAG_W, 27, line-address width; must equal ADDR_W - log2(BEATS*BEAT_W/8)
FWD_W, 32, load-forward/store-merge word width; divides BEAT_W
(Derived: CNT_W = log2(BEATS); BE_W = FWD_W/8)

Ports:
vb_clk  in  1  entry clock
cpurst_b  in  1  reset, asynchronous, active-low
rtu_yy_xx_async_flush  in  1  synchronous flush to IDLE
vb_create_en_x  in  1  allocate entry (IDLE only)
vb_create_addr  in  TAG_W  line address
vb_create_line_dirty  in  1  victim dirty flag
vb_create_data_vld  in  1  fill beat valid
vb_create_data_cnt  in  CNT_W  fill beat index
vb_create_data  in  BEAT_W  fill beat data
vb_clr_en_x  in  1  release request
dc_xx_addr  in  ADDR_W  lookup address (load or store)
dc_vb_st_vld  in  1  store at dc_xx_addr
dc_vb_st_merge  in  1  1 = merge the store; 0 = evict the line (legacy)
dc_vb_st_data  in  FWD_W  store data
dc_vb_st_be  in  BE_W  store byte enables
vb_wb_grant_x  in  1  BIU accepted writeback request
vb_wb_beat_rdy  in  1  BIU accepts current beat
vb_wb_cmplt_x  in  1  BIU writeback complete
vb_entry_vld_x  out  1  state != IDLE
vb_entry_biu_req_x  out  1  state == WB
vb_entryx_addr  out  TAG_W  stored line address
vb_wb_beat_vld  out  1  state == WD
vb_wb_beat_idx  out  CNT_W  current writeback beat
vb_wb_beat_last  out  1  beat_vld & idx == BEATS-1
vb_wb_data  out  BEAT_W  data[idx]
vb_fwd_vld_x  out  1  lookup hit while resident
vb_entryx_fwd_data  out  FWD_W  forwarded word
vb_hit_dirty_x  out  1  hit & dirty
vb_pop_en_x  out  1  entry retires this cycle
vb_entryx_dbginfo  out  3  current state

Behaviour:
- States: IDLE=0, RFC=1, RDY=2, WFC=3, WB=4, WD=5. Reset/flush: state IDLE, beat idx 0, dirty 0. Tag and data are not reset and are retained on flush. Reset values: all outputs 0 except addr/data/fwd_data, which are don't-care.
- IDLE: create_en -> RFC; tag and dirty latched.
- RFC: a beat with vld writes data[cnt]. A beat with cnt==BEATS-1 -> RDY next cycle. Beats may arrive in any order; the last index must arrive last.
- resident = state in {RDY, WB, WD, WFC}; hit = resident & (dc_xx_addr[ADDR_W-1 -: TAG_W] == tag). Word select = the offset bits above log2(BE_W). Forwarding is combinational from registered data, with no same-cycle store bypass.
- RDY, store hit with merge=1: bytes where be=1 are written into the selected word at the next edge; dirty <= 1; state stays RDY.
- RDY exit: clr_en, or (store hit & merge=0) -> WB if dirty, else IDLE with pop_en=1 that cycle.
- Simultaneous merge store and clr_en: the merge is applied, dirty is set, and the next state is WB.
- Stores hitting in WB/WD/WFC: no merge. fwd_vld and hit_dirty assert; upstream stalls.
- WB: grant -> WD, idx <= 0.
- WD: beat_vld=1; beat_rdy advances idx. beat_rdy on the last beat -> WFC, idx <= 0. No rdy -> data and idx held.
- WFC: cmplt -> IDLE, pop_en=1 same cycle.
- Flush takes priority over all transitions and aborts WD/WFC; pop_en is not asserted.
- create_en outside IDLE is ignored.

Test Plan:
- Create tag 0x1234567 clean; fill beats 0..3 = 0x11..,0x22..,0x33..,0x44.. -> RDY after 4th beat; lookup offset 0x14 -> fwd_vld=1, fwd_data=upper 32 bits of beat2.
- Clean RDY, clr_en -> pop_en=1 same cycle, IDLE next cycle, hit_dirty never asserted.
- Clean line, merge store be=4'b0011 data 0xAABBCCDD at offset 0x08 -> next cycle fwd shows low 16 bits 0xCCDD, hit_dirty=1. Then clr_en -> WB, grant -> WD; BIU stalls beat_rdy 2 cycles on beat1 -> beat1 held, 4 beats with merged data, last flagged; cmplt -> pop_en.
- Dirty line, store hit with merge=0 -> WB next cycle, biu_req=1.
- Flush during WD beat2 -> IDLE next cycle, beat_vld=0, pop_en=0; re-create works with idx 0.
- Merge store and clr_en in the same cycle on a clean line -> WB, writeback beat contains merged bytes.
